serial_adder: RTL and testbench

Parametrised bit-serial adder/subtractor, the sequential successor of the combinational half adder. It adds or subtracts two WIDTH-bit operands one bit per clock using a single full-adder cell and a carry flip-flop. Operation is controlled by a start/busy/done handshake. It sits in the combinational-circuit lab sequence as the first block that trades area for latency.

---
 rtl/serial_adder_pkg.sv | 19 +
 rtl/serial_adder_full_adder.sv | 33 +++
 rtl/serial_adder.sv | 151 +++++++++++++++
 tb/tb_serial_adder.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// -----------------------------------------------------------------------------
// serial_adder_pkg
//   Shared definitions for the bit-serial adder/subtractor.
//   - state_e     : FSM state encoding (IDLE=0, RUN=1, DONE=2)
//   - cnt_width() : bit-counter width, ceil(log2(WIDTH)), never below 1
// -----------------------------------------------------------------------------
package serial_adder_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   function automatic int cnt_width(input int w);
      return (w <= 2) ? 1 : $clog2(w);
   endfunction

endpackage : serial_adder_pkg

// File: rtl/serial_adder_full_adder.sv
// -----------------------------------------------------------------------------
// full_adder
//   One-bit full adder built from two half-adder stages and an OR gate.
//   Ports:
//     a_i, b_i   : operand bits
//     cin_i      : carry in
//     s_o        : sum bit
//     cout_o     : carry out
// -----------------------------------------------------------------------------
module full_adder (
   input  logic a_i,
   input  logic b_i,
   input  logic cin_i,
   output logic s_o,
   output logic cout_o
);

   logic ha1_s;
   logic ha1_c;
   logic ha2_c;

   // first half adder: a + b
   assign ha1_s = a_i ^ b_i;
   assign ha1_c = a_i & b_i;

   // second half adder: partial sum + carry in
   assign s_o   = ha1_s ^ cin_i;
   assign ha2_c = ha1_s & cin_i;

   // at most one of the two stages can generate a carry
   assign cout_o = ha1_c | ha2_c;

endmodule : full_adder

// File: rtl/serial_adder.sv
// -----------------------------------------------------------------------------
// serial_adder
//   Bit-serial adder/subtractor: one full-adder cell plus a carry flop process
//   the operands LSB first, one bit per clock.
//   Parameters:
//     WIDTH   : operand/result width, 2..32
//   Ports:
//     clk     : rising-edge clock
//     rst     : asynchronous active-high reset
//     start   : request, accepted in IDLE or DONE
//     SUB     : 0 = A+B+CIN, 1 = A-B-CIN (CIN is borrow-in)
//     A, B    : operands, captured with start
//     CIN     : carry/borrow in, captured with start
//     S       : registered result
//     COUT    : carry out (SUB: 1 means no borrow)
//     V       : signed overflow
//     busy    : high while bits are being processed
//     done    : one-cycle pulse when S/COUT/V update
//     state_o : debug view of the FSM state
//
//   Handshake: start is sampled on a rising edge only while busy is low
//   (IDLE or DONE); it is ignored during RUN. busy covers exactly WIDTH
//   cycles, then done pulses for one cycle with the new result. Holding or
//   re-asserting start during DONE chains the next operation with no gap.
// -----------------------------------------------------------------------------
module serial_adder
   import serial_adder_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             SUB,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             CIN,
   output logic [WIDTH-1:0] S,
   output logic             COUT,
   output logic             V,
   output logic             busy,
   output logic             done,
   output logic [1:0]       state_o
);

   localparam int CW = cnt_width(WIDTH);
   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] opa_q,   opa_d;
   logic [WIDTH-1:0] opb_q,   opb_d;
   logic [WIDTH-1:0] sreg_q,  sreg_d;
   logic             carry_q, carry_d;
   logic [CW-1:0]    cnt_q,   cnt_d;
   logic [WIDTH-1:0] s_q,     s_d;
   logic             cout_q,  cout_d;
   logic             v_q,     v_d;

   logic fa_s;
   logic fa_co;
   logic cin_msb;

   full_adder u_fa (
      .a_i    (opa_q[0]),
      .b_i    (opb_q[0]),
      .cin_i  (carry_q),
      .s_o    (fa_s),
      .cout_o (fa_co)
   );

   // carry into the bit currently in the adder; on the last bit this is the
   // carry into the MSB, used for signed overflow
   assign cin_msb = carry_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         opa_q   <= '0;
         opb_q   <= '0;
         sreg_q  <= '0;
         carry_q <= 1'b0;
         cnt_q   <= '0;
         s_q     <= '0;
         cout_q  <= 1'b0;
         v_q     <= 1'b0;
      end else begin
         state_q <= state_d;
         opa_q   <= opa_d;
         opb_q   <= opb_d;
         sreg_q  <= sreg_d;
         carry_q <= carry_d;
         cnt_q   <= cnt_d;
         s_q     <= s_d;
         cout_q  <= cout_d;
         v_q     <= v_d;
      end
   end

   always_comb begin
      state_d = state_q;
      opa_d   = opa_q;
      opb_d   = opb_q;
      sreg_d  = sreg_q;
      carry_d = carry_q;
      cnt_d   = cnt_q;
      s_d     = s_q;
      cout_d  = cout_q;
      v_d     = v_q;

      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               state_d = RUN;
               opa_d   = A;
               // subtraction is A + ~B + 1 - borrow_in, so the initial carry
               // is the inverted borrow
               opb_d   = SUB ? ~B : B;
               carry_d = CIN ^ SUB;
               cnt_d   = '0;
            end else begin
               state_d = IDLE;
            end
         end

         RUN: begin
            opa_d   = {1'b0, opa_q[WIDTH-1:1]};
            opb_d   = {1'b0, opb_q[WIDTH-1:1]};
            sreg_d  = {fa_s, sreg_q[WIDTH-1:1]};
            carry_d = fa_co;
            cnt_d   = cnt_q + CW'(1);
            if (cnt_q == LAST_BIT) begin
               state_d = DONE;
               // the final sum bit lands in the MSB on this same edge
               s_d     = {fa_s, sreg_q[WIDTH-1:1]};
               cout_d  = fa_co;
               v_d     = cin_msb ^ fa_co;
            end
         end

         default: state_d = IDLE;
      endcase
   end

   assign S       = s_q;
   assign COUT    = cout_q;
   assign V       = v_q;
   assign busy    = (state_q == RUN);
   assign done    = (state_q == DONE);
   assign state_o = state_q;

endmodule : serial_adder

// File: tb/tb_serial_adder.sv
module tb_serial_adder;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic         SUB;
   logic         CIN;
   logic [W-1:0] A;
   logic [W-1:0] B;
   logic [W-1:0] S;
   logic         COUT;
   logic         V;
   logic         busy;
   logic         done;
   logic [1:0]   state_o;

   int total  = 0;
   int bad    = 0;
   int cyc    = 0;
   int n_done = 0;

   // expected results packed as {COUT, V, S}
   logic [W+1:0] exp_q[$];
   logic [W+1:0] last_res;

   serial_adder #(.WIDTH(W)) dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .SUB     (SUB),
      .A       (A),
      .B       (B),
      .CIN     (CIN),
      .S       (S),
      .COUT    (COUT),
      .V       (V),
      .busy    (busy),
      .done    (done),
      .state_o (state_o)
   );

   // ---------------------------------------------------------------- clock
   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   // ---------------------------------------------------------------- helpers
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // reference: plain integer arithmetic on the operand values
   function automatic logic [W+1:0] ref_model(input logic [W-1:0] a, input logic [W-1:0] b,
                                               input logic cin, input logic sub);
      int ua, ub, sa, sb, c, r_u, r_s;
      logic co, ov;
      logic [W-1:0] s;
      ua = int'(a);
      ub = int'(b);
      sa = int'($signed(a));
      sb = int'($signed(b));
      c  = int'(cin);
      if (!sub) begin
         r_u = ua + ub + c;
         r_s = sa + sb + c;
         co  = (r_u >= (1 << W));
      end else begin
         r_u = ua - ub - c;
         r_s = sa - sb - c;
         co  = (r_u >= 0);
      end
      ov = (r_s > (1 << (W - 1)) - 1) || (r_s < -(1 << (W - 1)));
      s  = r_u[W-1:0];
      return {co, ov, s};
   endfunction

   // ---------------------------------------------------------------- monitor
   always @(negedge clk) begin
      logic [W+1:0] e;
      if (!rst) begin
         check("busy_done_excl", {31'b0, busy & done}, 32'd0);
         if (done) begin
            n_done++;
            check("sb_has_entry", {31'b0, exp_q.size() > 0}, 32'd1);
            if (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               check("S", {24'b0, S}, {24'b0, e[W-1:0]});
               check("COUT", {31'b0, COUT}, {31'b0, e[W+1]});
               check("V", {31'b0, V}, {31'b0, e[W]});
            end
         end
      end
   end

   // ---------------------------------------------------------------- driver
   // Issues one operation from the current negedge and returns at the
   // negedge of its done cycle. inject_at >= 0 pulses a stray start with new
   // operands that many cycles into the run.
   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic cin, input logic sub, input int inject_at);
      int           sc, busy_n;
      bit           seen;
      logic [W+1:0] e;
      e = ref_model(a, b, cin, sub);
      A = a; B = b; CIN = cin; SUB = sub; start = 1'b1;
      sc = cyc;
      exp_q.push_back(e);
      @(negedge clk);
      start = 1'b0;
      A = W'($urandom); B = W'($urandom); CIN = 1'($urandom); SUB = 1'($urandom);
      busy_n = 0;
      seen   = 1'b0;
      for (int i = 0; i < W + 4; i++) begin
         if (done) begin
            seen = 1'b1;
            break;
         end
         if (busy) begin
            busy_n++;
            check("hold_during_run", {22'b0, COUT, V, S}, {22'b0, last_res});
         end
         start = (i == inject_at);
         if (i == inject_at) A = 8'hAA;
         @(negedge clk);
      end
      start = 1'b0;
      check("done_seen", {31'b0, seen}, 32'd1);
      check("latency", cyc - sc, W + 1);
      check("busy_cycles", busy_n, W);
      last_res = e;
   endtask

   // ---------------------------------------------------------------- stimulus
   initial begin
      int nd;
      rst = 1'b1; start = 1'b0; SUB = 1'b0; CIN = 1'b0; A = '0; B = '0;
      last_res = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("rst_S", {24'b0, S}, 32'd0);
      check("rst_COUT", {31'b0, COUT}, 32'd0);
      check("rst_V", {31'b0, V}, 32'd0);
      check("rst_busy", {31'b0, busy}, 32'd0);
      check("rst_done", {31'b0, done}, 32'd0);
      check("rst_state", {30'b0, state_o}, 32'd0);

      // directed arithmetic cases
      run_op(8'h5A, 8'h3C, 1'b0, 1'b0, -1);
      @(negedge clk);
      run_op(8'hFF, 8'h01, 1'b0, 1'b0, -1);
      @(negedge clk);
      run_op(8'h10, 8'h20, 1'b0, 1'b1, -1);
      @(negedge clk);
      run_op(8'h80, 8'h01, 1'b0, 1'b1, -1);
      // back-to-back: start again in the DONE cycle
      run_op(8'h0F, 8'h01, 1'b0, 1'b0, -1);
      repeat (2) @(negedge clk);
      check("idle_after_done", {31'b0, busy | done}, 32'd0);

      // stray start during RUN must be ignored
      run_op(8'h01, 8'h01, 1'b0, 1'b0, 2);
      repeat (W + 3) @(negedge clk);

      // reset in the middle of an operation
      A = 8'h33; B = 8'h44; CIN = 1'b0; SUB = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check("abort_busy", {31'b0, busy}, 32'd0);
      check("abort_done", {31'b0, done}, 32'd0);
      check("abort_S", {24'b0, S}, 32'd0);
      check("abort_COUT_V", {30'b0, COUT, V}, 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      last_res = '0;
      nd = n_done;
      repeat (W + 3) @(negedge clk);
      check("no_done_after_abort", n_done, nd);

      // randomized operations, mixing idle gaps with back-to-back starts
      for (int k = 0; k < 40; k++) begin
         run_op(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom), -1);
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      repeat (3) @(negedge clk);
      check("sb_empty", exp_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // absolute time bound
   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, got running expected finished");
      $fatal(1);
   end

endmodule : tb_serial_adder
